// File: rtl/dffram_port_arbiter_pkg.sv
// dffram_arb_pkg: shared types, widths and byte-enable helper for the DFFRAM port arbiter
package dffram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_WB} owner_e;
  localparam int RAM_DW = 32;
  localparam int RAM_BW = 4;
  function automatic logic [RAM_BW-1:0] byte_we(input logic [RAM_BW-1:0] sel, input logic we);
    return sel & {RAM_BW{we}};
  endfunction
endpackage

// File: rtl/dffram_port_arbiter_if.sv
// dffram_port_arbiter_if: programmer, Wishbone, core and DFFRAM signals seen by the port arbiter
interface dffram_port_arbiter_if
  import dffram_arb_pkg::*;
#(
  parameter int AW = 8
);
  logic              prog_we_i;
  logic [AW-1:0]     prog_addr_i;
  logic [RAM_DW-1:0] prog_wdata_i;
  logic              wbs_stb_i;
  logic              wbs_cyc_i;
  logic              wbs_we_i;
  logic [RAM_BW-1:0] wbs_sel_i;
  logic [RAM_DW-1:0] wbs_dat_i;
  logic [31:0]       wbs_adr_i;
  logic              wbs_ack_o;
  logic [RAM_DW-1:0] wbs_dat_o;
  logic              core_req_i;
  logic              core_we_i;
  logic [RAM_BW-1:0] core_be_i;
  logic [AW-1:0]     core_addr_i;
  logic [RAM_DW-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [RAM_DW-1:0] core_rdata_o;
  logic              ram_en_o;
  logic [RAM_BW-1:0] ram_we_o;
  logic [AW-1:0]     ram_a_o;
  logic [RAM_DW-1:0] ram_di_o;
  logic [RAM_DW-1:0] ram_do_i;
  modport slave (
    input  prog_we_i, prog_addr_i, prog_wdata_i,
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output ram_en_o, ram_we_o, ram_a_o, ram_di_o,
    input  ram_do_i
  );
  modport master (
    output prog_we_i, prog_addr_i, prog_wdata_i,
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ram_en_o, ram_we_o, ram_a_o, ram_di_o,
    output ram_do_i
  );
endinterface

// File: rtl/dffram_port_arbiter_rr_arb2.sv
// dffram_rr_arb2: two-way round-robin arbiter; on a tie the side not granted last wins, last grant resets to a
module dffram_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_a;
  assign gnt_a = req_a & (~req_b | ~last_a);
  assign gnt_b = req_b & ~gnt_a;
  always_ff @(posedge clk)
    if (rst) last_a <= 1'b1;
    else if (gnt_a | gnt_b) last_a <= gnt_a;
endmodule

// File: rtl/dffram_port_arbiter.sv
// dffram_port_arbiter: shares one DFFRAM between programmer, Wishbone and core; DFFRAM_ARB_STALL_CNT_EN adds a stall counter
module dffram_port_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int          AW      = 8,
  parameter logic [31:0] WB_BASE = 32'h3000_0000,
  parameter logic [31:0] WB_MASK = 32'hFFFF_FC00
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
`ifdef DFFRAM_ARB_STALL_CNT_EN
  input  logic        stall_clr_i,
  output logic [15:0] stall_cnt_o,
`endif
  dffram_port_arbiter_if.slave bus
);
  logic              live;
  logic              prog;
  logic              wb_req;
  logic              wb_gnt;
  logic              core_gnt;
  logic              ack_q;
  logic [AW-1:0]     wb_addr;
  owner_e            owner_q;
  owner_e            owner_d;
  logic [RAM_DW-1:0] wb_dat_q;
  logic [RAM_DW-1:0] core_dat_q;
  // reset is applied to every output in the same cycle so an in-flight read is dropped silently
  assign live    = ~wb_rst_i;
  assign prog    = bus.prog_we_i & live;
  assign wb_req  = bus.wbs_stb_i & bus.wbs_cyc_i & ((bus.wbs_adr_i & WB_MASK) == WB_BASE) & ~bus.wbs_ack_o;
  assign wb_addr = bus.wbs_adr_i[AW+1:2];
  dffram_rr_arb2 u_rr (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .req_a (wb_req & ~prog & live),
    .req_b (bus.core_req_i & ~prog & live),
    .gnt_a (wb_gnt),
    .gnt_b (core_gnt)
  );
  assign bus.ram_en_o      = prog | wb_gnt | core_gnt;
  assign bus.ram_we_o      = prog ? {RAM_BW{1'b1}} :
                             wb_gnt ? byte_we(bus.wbs_sel_i, bus.wbs_we_i) :
                             core_gnt ? byte_we(bus.core_be_i, bus.core_we_i) : '0;
  assign bus.ram_a_o       = prog ? bus.prog_addr_i : wb_gnt ? wb_addr : bus.core_addr_i;
  assign bus.ram_di_o      = prog ? bus.prog_wdata_i : wb_gnt ? bus.wbs_dat_i : bus.core_wdata_i;
  assign bus.core_gnt_o    = core_gnt;
  assign bus.wbs_ack_o     = ack_q & live;
  assign bus.wbs_dat_o     = ~live ? '0 : owner_q == OWN_WB ? bus.ram_do_i : wb_dat_q;
  assign bus.core_rvalid_o = live & (owner_q == OWN_CORE);
  assign bus.core_rdata_o  = ~live ? '0 : owner_q == OWN_CORE ? bus.ram_do_i : core_dat_q;
  always_comb
    owner_d = (core_gnt & ~bus.core_we_i) ? OWN_CORE : (wb_gnt & ~bus.wbs_we_i) ? OWN_WB : OWN_NONE;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      owner_q    <= OWN_NONE;
      wb_dat_q   <= '0;
      core_dat_q <= '0;
    end else begin
      ack_q   <= wb_gnt;
      owner_q <= owner_d;
      if (owner_q == OWN_WB) wb_dat_q <= bus.ram_do_i;
      if (owner_q == OWN_CORE) core_dat_q <= bus.ram_do_i;
    end
`ifdef DFFRAM_ARB_STALL_CNT_EN
  logic stall;
  assign stall = (wb_req & ~wb_gnt) | (bus.core_req_i & ~core_gnt);
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i || stall_clr_i) stall_cnt_o <= '0;
    else if (stall && ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 16'd1;
`endif
endmodule
